// File: rtl/pxl_arb_pkg.sv
// pxl_arb_pkg: shared types and constants for the pixel-write arbiter.
//   arb_state_e      : arbiter FSM state (ARB = choosing owner, BURST = owner streaming)
//   DEF_*            : default parameter values for pxl_write_arbiter
//   FB_DEPTH_640X480 : number of addressable pixels in a 640x480 framebuffer
//   rr_next()        : round-robin increment with wrap at n
package pxl_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_ADDR_W    = 19;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_MAX_BURST = 8;

  localparam int unsigned FB_WIDTH         = 640;
  localparam int unsigned FB_HEIGHT        = 480;
  localparam int unsigned FB_DEPTH_640X480 = FB_WIDTH * FB_HEIGHT;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : pxl_arb_pkg

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Selects the first set bit of req_i at or after ptr_i, wrapping NREQ-1 -> 0.
//   req_i [NREQ]        : request vector
//   ptr_i [log2(NREQ)]  : highest-priority index for this pick (must be < NREQ)
//   gnt_o [NREQ]        : one-hot winner, zero when no request
//   idx_o [log2(NREQ)]  : binary index of the winner (0 when none)
//   any_o               : at least one request is set
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  // Rotate-scan starting at ptr_i; first hit wins.
  always_comb begin
    int unsigned cand;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    cand  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr_i) + i) % NREQ;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt_o[IDX_W'(cand)]  = 1'b1;
        idx_o                = IDX_W'(cand);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/pxl_write_arbiter.sv
// pxl_write_arbiter: round-robin burst arbiter for NREQ pixel writers sharing
// one framebuffer write port.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   req_valid_i [NREQ] : per-requester write valid
//   req_addr_i  [NREQ][ADDR_W], req_data_i [NREQ][DATA_W] : per-requester beat
//   req_ready_o [NREQ] : combinational accept, at most one bit set
//   vblank_i           : vertical blanking from the HDMI timing
//   pxl_addr_o, pxl_data_o, pxl_en_o : registered write to the pixel port
//   grant_o [NREQ]     : one-hot current owner, zero when idle
//   oob_o              : one-cycle pulse for an accepted address >= FB_DEPTH
// Build option: define PXL_ARB_VBLANK_GATE_EN to allow writes only while
// vblank_i is high; otherwise the write gate is always open.
module pxl_write_arbiter
  import pxl_arb_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned FB_DEPTH  = FB_DEPTH_640X480
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic                         vblank_i,
  output logic [ADDR_W-1:0]            pxl_addr_o,
  output logic [DATA_W-1:0]            pxl_data_o,
  output logic                         pxl_en_o,
  output logic [NREQ-1:0]              grant_o,
  output logic                         oob_o
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W:0]   FB_LIM   = (ADDR_W + 1)'(FB_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_LIM = CNT_W'(MAX_BURST);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [ADDR_W-1:0] pxl_addr_q;
  logic [DATA_W-1:0] pxl_data_q;
  logic              pxl_en_q;
  logic              oob_q;

  logic              gate_c;
  logic [NREQ-1:0]   win_gnt_c;
  logic [IDX_W-1:0]  win_idx_c;
  logic              win_any_c;
  logic [NREQ-1:0]   ready_c;
  logic [NREQ-1:0]   grant_c;
  logic [IDX_W-1:0]  acc_idx_c;
  logic              accept_c;

  logic [ADDR_W-1:0] pxl_addr_d;
  logic [DATA_W-1:0] pxl_data_d;
  logic              in_range_d;

`ifdef PXL_ARB_VBLANK_GATE_EN
  assign gate_c = vblank_i;
`else
  // Gate held open; vblank_i is folded in only so it is not a dangling input.
  assign gate_c = vblank_i | 1'b1;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt_c),
    .idx_o (win_idx_c),
    .any_o (win_any_c)
  );

  // Ready/grant: new winner in ARB, current owner in BURST; nothing in reset.
  always_comb begin
    ready_c   = '0;
    grant_c   = '0;
    acc_idx_c = win_idx_c;
    if (!reset_i) begin
      if (state_q == ARB) begin
        if (gate_c && win_any_c) begin
          ready_c = win_gnt_c;
          grant_c = win_gnt_c;
        end
      end else begin
        acc_idx_c        = owner_q;
        grant_c[owner_q] = 1'b1;
        if (gate_c && req_valid_i[owner_q] && (beat_cnt_q < BURST_LIM)) begin
          ready_c[owner_q] = 1'b1;
        end
      end
    end
  end

  assign accept_c   = |(ready_c & req_valid_i);
  assign pxl_addr_d = req_addr_i[acc_idx_c];
  assign pxl_data_d = req_data_i[acc_idx_c];
  assign in_range_d = ({1'b0, pxl_addr_d} < FB_LIM);

  // FSM and registered write port. Out-of-range beats are consumed but only pulse oob.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      pxl_addr_q <= '0;
      pxl_data_q <= '0;
      pxl_en_q   <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      pxl_en_q <= 1'b0;
      oob_q    <= 1'b0;
      if (accept_c) begin
        pxl_addr_q <= pxl_addr_d;
        pxl_data_q <= pxl_data_d;
        pxl_en_q   <= in_range_d;
        oob_q      <= !in_range_d;
      end
      case (state_q)
        ARB: begin
          if (accept_c) begin
            if (MAX_BURST == 1) begin
              rr_ptr_q <= IDX_W'(rr_next(32'(win_idx_c), NREQ));
            end else begin
              state_q    <= BURST;
              owner_q    <= win_idx_c;
              beat_cnt_q <= CNT_W'(1);
            end
          end
        end
        BURST: begin
          // Any cycle without a beat is the exit cycle.
          if (accept_c) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end else begin
            state_q    <= ARB;
            rr_ptr_q   <= IDX_W'(rr_next(32'(owner_q), NREQ));
            beat_cnt_q <= '0;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign req_ready_o = ready_c;
  assign grant_o     = grant_c;
  assign pxl_addr_o  = pxl_addr_q;
  assign pxl_data_o  = pxl_data_q;
  assign pxl_en_o    = pxl_en_q;
  assign oob_o       = oob_q;

endmodule : pxl_write_arbiter

// File: doc/pxl_write_arbiter.md
PXL_WRITE_ARBITER -- requirements
Module: pxl_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of pixel-write requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 19: pixel address width (640x480 framebuffer).
REQ-003 SHALL have parameter DATA_W, default 16: pixel data width.
REQ-004 SHALL have parameter MAX_BURST, default 8: maximum consecutive beats per grant (>=1).
REQ-005 SHALL have parameter FB_DEPTH, default 307200: number of valid pixel addresses.
REQ-006 SHALL have port clk_i, input, 1: the only clock.
REQ-007 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port req_valid_i, input, NREQ: per-requester write valid.
REQ-009 SHALL have port req_addr_i, input, NREQ x ADDR_W: per-requester pixel address.
REQ-010 SHALL have port req_data_i, input, NREQ x DATA_W: per-requester pixel data.
REQ-011 SHALL have port req_ready_o, output, NREQ: per-requester accept, combinational, at most one bit set.
REQ-012 SHALL have port vblank_i, input, 1: high during vertical blanking, from the HDMI controller timing.
REQ-013 SHALL have port pxl_addr_o, output, ADDR_W: write address to the controller pixel port.
REQ-014 SHALL have port pxl_data_o, output, DATA_W: write data to the controller pixel port.
REQ-015 SHALL have port pxl_en_o, output, 1: one-cycle write strobe.
REQ-016 SHALL have port grant_o, output, NREQ: one-hot current owner, zero when idle.
REQ-017 SHALL have port oob_o, output, 1: one-cycle pulse on an accepted out-of-range address.

Function
REQ-018 SHALL transfer a beat on cycle where req_valid_i[k] and req_ready_o[k] are both 1.
REQ-019 SHALL register each beat: pxl_addr_o/pxl_data_o/pxl_en_o reflect it exactly 1 cycle after the handshake.
REQ-020 SHALL implement FSM states ARB and BURST.
REQ-021 In ARB, when the write gate is open and any valid is set, SHALL grant the first valid requester at or after rr_ptr (wrapping NREQ-1 -> 0), accept its beat that same cycle, set beat_cnt=1, and go to BURST (stay in ARB with rr_ptr=winner+1 if MAX_BURST=1).
REQ-022 In BURST, SHALL assert ready to the owner while its valid is high, beat_cnt<MAX_BURST, and the gate is open; each beat increments beat_cnt.
REQ-023 SHALL leave BURST for ARB when owner valid is low, beat_cnt==MAX_BURST, or the gate closes; rr_ptr becomes owner+1 mod NREQ; no beat is accepted on the exit cycle.
REQ-024 Non-owners SHALL never see ready; a requester dropping valid SHALL not stall others beyond one exit cycle.
REQ-025 An accepted beat with addr >= FB_DEPTH SHALL be consumed, SHALL NOT raise pxl_en_o, and SHALL pulse oob_o 1 cycle after the handshake.
REQ-026 With any requester continuously valid, each other valid requester SHALL be granted within (NREQ-1)*(MAX_BURST+1) cycles of gate-open time.

Reset
REQ-027 On reset_i high at a clock edge: state=ARB, rr_ptr=0, beat_cnt=0, pxl_en_o=0, pxl_addr_o=0, pxl_data_o=0, oob_o=0, grant_o=0, req_ready_o=0.
REQ-028 Reset mid-burst SHALL drop the grant without emitting a strobe on the following cycle.

Configuration
REQ-029 Macro PXL_ARB_VBLANK_GATE_EN defined: write gate = vblank_i (tear-free writes only during blanking).
REQ-030 Macro PXL_ARB_VBLANK_GATE_EN undefined: gate is constantly open and vblank_i is ignored.

Structure
REQ-031 Package pxl_arb_pkg SHALL hold the FSM state enum, default width constants, and the 640x480 FB_DEPTH constant.
REQ-032 Round-robin winner selection SHALL be a sub-module rr_arbiter (request vector, pointer -> one-hot grant).

Verification
REQ-033 Single requester 0 valid, addr 5, data 16'hABCD -> pxl_en_o=1 with same addr/data one cycle later.
REQ-034 All 4 valid continuously, MAX_BURST=8 -> grants 0,1,2,3,0 in order, 8 beats each, one idle exit cycle between.
REQ-035 Requester 2 drops valid after 3 beats -> ARB next cycle, rr_ptr=3, requester 3 granted.
REQ-036 Addr 307200 accepted -> oob_o pulses, pxl_en_o stays 0.
REQ-037 With PXL_ARB_VBLANK_GATE_EN, vblank_i low -> all ready 0; vblank_i falls mid-burst -> burst ends, no beat on that cycle.
REQ-038 reset_i asserted during a burst -> next cycle all outputs 0, first grant after reset goes to requester 0.
